// File: rtl/imem_responder.sv
// Instruction-memory responder that serves the fetch unit's dual-address read interface.
// It holds a word array that a separate load port writes, returns two read words combinationally,
// and delays imem_rvalid_o by a programmable number of wait states.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   imem_ren_i, imem_addr{0,1}_i   fetch request and byte addresses
//   imem_rdata{0,1}_o              words at the two addresses (FILL_WORD when bad)
//   imem_rvalid_o                  read data consumable this cycle
//   load_we_i/addr_i/wdata_i       boot/load write port
//   imem_err_o, err_sticky_o       live and latched error flags; err_clr_i clears latch
module imem_responder #(
  parameter int unsigned             INSTR_WIDTH = 32,  // core XLEN
  parameter int unsigned             ADDR_WIDTH  = 32,  // core XLEN
  parameter int unsigned             DEPTH_WORDS = 1024,
  parameter int unsigned             WAIT_STATES = 0,
  parameter logic [INSTR_WIDTH-1:0]  FILL_WORD   = 32'hD503201F
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   imem_ren_i,
  input  logic [ADDR_WIDTH-1:0]  imem_addr0_i,
  input  logic [ADDR_WIDTH-1:0]  imem_addr1_i,
  output logic [INSTR_WIDTH-1:0] imem_rdata0_o,
  output logic [INSTR_WIDTH-1:0] imem_rdata1_o,
  output logic                   imem_rvalid_o,
  input  logic                   load_we_i,
  input  logic [ADDR_WIDTH-1:0]  load_addr_i,
  input  logic [INSTR_WIDTH-1:0] load_wdata_i,
  output logic                   imem_err_o,
  output logic                   err_sticky_o,
  input  logic                   err_clr_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS    = WAIT_STATES[3:0];

  // A byte address is usable when word-aligned and every bit above the
  // word index is zero, i.e. addr < DEPTH_WORDS*4. No index ever wraps.
  function automatic logic f_addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
  endfunction

  // Instruction storage, deliberately not reset.
  logic [INSTR_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic                  r_ren;
  logic [3:0]            r_cnt;
  logic                  r_sticky;

  logic            w_ok0;
  logic            w_ok1;
  logic            w_load_ok;
  logic            w_load_bad;
  logic            w_req;
  logic            w_match;
  logic [4:0]      w_inc;
  logic [3:0]      w_c;
  logic [IDX_W-1:0] w_idx0;
  logic [IDX_W-1:0] w_idx1;
  logic [IDX_W-1:0] w_lidx;

  assign w_ok0      = f_addr_ok(imem_addr0_i);
  assign w_ok1      = f_addr_ok(imem_addr1_i);
  assign w_load_ok  = f_addr_ok(load_addr_i);
  assign w_load_bad = load_we_i && !w_load_ok;

  assign w_idx0 = imem_addr0_i[2 +: IDX_W];
  assign w_idx1 = imem_addr1_i[2 +: IDX_W];
  assign w_lidx = load_addr_i[2 +: IDX_W];

  // Combinational read. A same-cycle load write lands at the clock edge,
  // so a colliding read sees the old word.
  assign imem_rdata0_o = w_ok0 ? r_mem[w_idx0] : FILL_WORD;
  assign imem_rdata1_o = w_ok1 ? r_mem[w_idx1] : FILL_WORD;

  assign imem_err_o = imem_ren_i && !(w_ok0 && w_ok1);

  // Wait-state count: only a request identical to last cycle's (and last
  // cycle's was live) keeps counting; anything else restarts at zero, which
  // is what prevents a late rvalid for an abandoned request.
  assign w_req   = imem_ren_i && !load_we_i;
  assign w_match = imem_ren_i && r_ren &&
                   (imem_addr0_i == r_addr0) && (imem_addr1_i == r_addr1);
  assign w_inc   = {1'b0, r_cnt} + 5'd1;

  always_comb begin
    w_c = 4'd0;
    if (w_match) begin
      w_c = (w_inc > {1'b0, WS}) ? WS : w_inc[3:0];
    end
  end

  assign imem_rvalid_o = w_req && (w_c == WS);
  assign err_sticky_o  = r_sticky;

  always_ff @(posedge clk_i) begin
    if (load_we_i && w_load_ok) begin
      r_mem[w_lidx] <= load_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_ren    <= 1'b0;
      r_cnt    <= 4'd0;
      r_sticky <= 1'b0;
    end else begin
      r_addr0 <= imem_addr0_i;
      r_addr1 <= imem_addr1_i;
      r_ren   <= w_req;
      r_cnt   <= w_req ? w_c : 4'd0;
      // A new error in the same cycle as a clear keeps the flag set.
      if (imem_err_o || w_load_bad) begin
        r_sticky <= 1'b1;
      end else if (err_clr_i) begin
        r_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam logic [31:0] FILL = 32'hD503201F;

  logic        clk;
  logic        rst_n;
  logic        ren;
  logic [31:0] a0;
  logic [31:0] a1;
  logic        we;
  logic [31:0] la;
  logic [31:0] wd;
  logic        clr;

  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic        rv  [3];
  logic        er  [3];
  logic        st  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_ni(rst_n), .imem_ren_i(ren),
    .imem_addr0_i(a0), .imem_addr1_i(a1),
    .imem_rdata0_o(rd0[0]), .imem_rdata1_o(rd1[0]), .imem_rvalid_o(rv[0]),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd),
    .imem_err_o(er[0]), .err_sticky_o(st[0]), .err_clr_i(clr)
  );

  imem_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk_i(clk), .rst_ni(rst_n), .imem_ren_i(ren),
    .imem_addr0_i(a0), .imem_addr1_i(a1),
    .imem_rdata0_o(rd0[1]), .imem_rdata1_o(rd1[1]), .imem_rvalid_o(rv[1]),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd),
    .imem_err_o(er[1]), .err_sticky_o(st[1]), .err_clr_i(clr)
  );

  imem_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_ni(rst_n), .imem_ren_i(ren),
    .imem_addr0_i(a0), .imem_addr1_i(a1),
    .imem_rdata0_o(rd0[2]), .imem_rdata1_o(rd1[2]), .imem_rvalid_o(rv[2]),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd),
    .imem_err_o(er[2]), .err_sticky_o(st[2]), .err_clr_i(clr)
  );

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic obs_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ren = 1'b0;
    we  = 1'b1;
    la  = addr;
    wd  = data;
  endtask

  // Drive one request cycle at the falling edge, then let outputs settle.
  task automatic step(input logic r, input logic [31:0] x0, input logic [31:0] x1);
    @(negedge clk);
    ren = r;
    a0  = x0;
    a1  = x1;
    we  = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ren = 1'b0; a0 = '0; a1 = '0;
    we = 1'b0; la = '0; wd = '0; clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_push($sformatf("rst_rvalid%0d", i), 32'd0);
      exp_push($sformatf("rst_sticky%0d", i), 32'd0);
      exp_push($sformatf("rst_err%0d", i), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      obs_chk({31'd0, rv[i]});
      obs_chk({31'd0, st[i]});
      obs_chk({31'd0, er[i]});
    end
    // Request held in reset: wait-state counter cannot advance
    step(1'b1, 32'h0, 32'h4);
    exp_push("rst_hold_rvalid_ws3", 32'd0);
    obs_chk({31'd0, rv[2]});
    @(negedge clk);
    ren   = 1'b0;
    rst_n = 1'b1;

    // Program the array
    load(32'h0, 32'h8B020020);
    load(32'h4, 32'h8B030041);
    load(32'h8, 32'h11111111);
    load(32'hC, 32'h22222222);

    // WAIT_STATES=0: same-cycle response
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws0_rvalid", 32'd1);
    exp_push("ws0_rdata0", 32'h8B020020);
    exp_push("ws0_rdata1", 32'h8B030041);
    exp_push("ws0_err", 32'd0);
    obs_chk({31'd0, rv[0]});
    obs_chk(rd0[0]);
    obs_chk(rd1[0]);
    obs_chk({31'd0, er[0]});

    // WAIT_STATES=2: held request -> 0,0,1,1
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h8, 32'hC);
      exp_push($sformatf("ws2_hold_c%0d", k), (k >= 2) ? 32'd1 : 32'd0);
      obs_chk({31'd0, rv[1]});
    end
    exp_push("ws2_rdata0", 32'h11111111);
    exp_push("ws2_rdata1", 32'h22222222);
    obs_chk(rd0[1]);
    obs_chk(rd1[1]);

    // Address change mid-wait restarts the count
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws2_chg_a", 32'd0); obs_chk({31'd0, rv[1]});
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws2_chg_b", 32'd0); obs_chk({31'd0, rv[1]});
    step(1'b1, 32'h8, 32'hC);
    exp_push("ws2_chg_c", 32'd0); obs_chk({31'd0, rv[1]});
    step(1'b1, 32'h8, 32'hC);
    exp_push("ws2_chg_d", 32'd0); obs_chk({31'd0, rv[1]});
    step(1'b1, 32'h8, 32'hC);
    exp_push("ws2_chg_e", 32'd1); obs_chk({31'd0, rv[1]});

    // ren drop abandons the request: no late rvalid
    step(1'b0, 32'h8, 32'hC);
    exp_push("ws2_drop_rvalid", 32'd0); obs_chk({31'd0, rv[1]});
    step(1'b1, 32'h8, 32'hC);
    exp_push("ws2_resume_rvalid", 32'd0); obs_chk({31'd0, rv[1]});

    // Collision: read-before-write, rvalid suppressed
    @(negedge clk);
    ren = 1'b1; a0 = 32'h8; a1 = 32'hC;
    we = 1'b1; la = 32'h8; wd = 32'h33333333;
    #1;
    exp_push("coll_rvalid", 32'd0);
    exp_push("coll_old_data", 32'h11111111);
    obs_chk({31'd0, rv[0]});
    obs_chk(rd0[0]);
    step(1'b1, 32'h8, 32'hC);
    exp_push("coll_new_rvalid", 32'd1);
    exp_push("coll_new_data", 32'h33333333);
    obs_chk({31'd0, rv[0]});
    obs_chk(rd0[0]);

    // Last word / one past the end
    step(1'b1, 32'hFFC, 32'h1000);
    exp_push("oor_rdata1", FILL);
    exp_push("oor_err", 32'd1);
    exp_push("oor_rvalid", 32'd1);
    obs_chk(rd1[0]);
    obs_chk({31'd0, er[0]});
    obs_chk({31'd0, rv[0]});
    step(1'b0, 32'h0, 32'h4);
    clr = 1'b1;
    exp_push("oor_sticky_set", 32'd1);
    exp_push("idle_err", 32'd0);
    obs_chk({31'd0, st[0]});
    obs_chk({31'd0, er[0]});
    step(1'b0, 32'h0, 32'h4);
    clr = 1'b0;
    exp_push("oor_sticky_clr", 32'd0);
    obs_chk({31'd0, st[0]});

    // Misaligned read, with a coinciding clear (set must win)
    step(1'b1, 32'h2, 32'h4);
    clr = 1'b1;
    exp_push("mis_rdata0", FILL);
    exp_push("mis_rdata1", 32'h8B030041);
    exp_push("mis_err", 32'd1);
    obs_chk(rd0[0]);
    obs_chk(rd1[0]);
    obs_chk({31'd0, er[0]});
    step(1'b0, 32'h0, 32'h4);
    clr = 1'b0;
    exp_push("mis_set_wins", 32'd1);
    obs_chk({31'd0, st[0]});
    step(1'b0, 32'h0, 32'h4);
    clr = 1'b1;
    step(1'b0, 32'h0, 32'h4);
    clr = 1'b0;
    exp_push("mis_sticky_clr", 32'd0);
    obs_chk({31'd0, st[0]});

    // Misaligned load is dropped and latches the error
    load(32'h5, 32'h44444444);
    step(1'b1, 32'h4, 32'h8);
    exp_push("badload_sticky", 32'd1);
    exp_push("badload_word4", 32'h8B030041);
    exp_push("badload_word8", 32'h33333333);
    obs_chk({31'd0, st[0]});
    obs_chk(rd0[0]);
    obs_chk(rd1[0]);

    // WAIT_STATES=3: reset after first wait cycle, request held through release
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws3_pre_rvalid", 32'd0); obs_chk({31'd0, rv[2]});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_push("ws3_in_rst_rvalid", 32'd0); obs_chk({31'd0, rv[2]});
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) exp_push($sformatf("rst_sticky_clear%0d", i), 32'd0);
    for (int i = 0; i < 3; i++) obs_chk({31'd0, st[i]});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_push("ws3_post_c1", 32'd0); obs_chk({31'd0, rv[2]});
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws3_post_c2", 32'd0); obs_chk({31'd0, rv[2]});
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws3_post_c3", 32'd0); obs_chk({31'd0, rv[2]});
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws3_post_c4", 32'd1); obs_chk({31'd0, rv[2]});
    step(1'b1, 32'h0, 32'h4);
    exp_push("ws3_post_c5", 32'd1); obs_chk({31'd0, rv[2]});
    exp_push("ws3_rdata0", 32'h8B020020); obs_chk(rd0[2]);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the slave end of the fetch unit's dual-address imem read interface (ren, addr0/addr1, rdata0/rdata1, rvalid).
- Holds a word-addressed instruction array that a separate load/boot port writes.
- Two independent read ports return the words at addr0 and addr1.
- A programmable wait-state counter controls when rvalid asserts, so the team can model slow memory behind fetch.

Parameters:
- INSTR_WIDTH, core_pkg::XLEN: instruction word width.
- ADDR_WIDTH, core_pkg::XLEN: byte-address width.
- DEPTH_WORDS, 1024: array depth in words; must be a power of 2 and at least 2.
- WAIT_STATES, 0: extra cycles a request must be held before rvalid; range 0..15.
- FILL_WORD, 32'hD503201F: data returned for an out-of-range or misaligned address (LEGv8 NOP).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- imem_ren_i  in  1  read request from fetch.
- imem_addr0_i  in  ADDR_WIDTH  byte address, slot 0.
- imem_addr1_i  in  ADDR_WIDTH  byte address, slot 1.
- imem_rdata0_o  out  INSTR_WIDTH  word at addr0.
- imem_rdata1_o  out  INSTR_WIDTH  word at addr1.
- imem_rvalid_o  out  1  rdata0/rdata1 are valid this cycle.
- load_we_i  in  1  load-port write enable.
- load_addr_i  in  ADDR_WIDTH  load byte address.
- load_wdata_i  in  INSTR_WIDTH  load data.
- imem_err_o  out  1  current request is misaligned or out of range.
- err_sticky_o  out  1  latched error flag.
- err_clr_i  in  1  clears err_sticky_o.

Behaviour:
- Array is not reset. Contents are undefined until written. rst_ni does not alter contents.
- Word index = addr[2 +: log2(DEPTH_WORDS)].
- An address is in range when addr < DEPTH_WORDS*4. It is aligned when addr[1:0] == 0.
- Read data is combinational from the array:
  - rdataN = array[indexN] when addrN is aligned and in range; otherwise FILL_WORD.
  - rdataN is driven regardless of ren; consumers qualify it with rvalid.
- Load write:
  - On posedge with load_we_i=1 and load_addr_i aligned and in range, array[index] <= load_wdata_i.
  - A bad load address is silently dropped and sets err_sticky_o.
- Read/write collision in the same cycle returns the old data (read-before-write). rvalid is 0 in any cycle with load_we_i=1, so the old data is never consumed.
- Wait-state tracking registers:
  - addr0_q, addr1_q, ren_q, cnt_q (4 bits).
  - Reset values: 0, 0, 0, 0.
- Per-cycle logic:
  - match = imem_ren_i && ren_q && addr0_i==addr0_q && addr1_i==addr1_q.
  - c = match ? min(cnt_q+1, WAIT_STATES) : 0.
  - imem_rvalid_o = imem_ren_i && !load_we_i && (c == WAIT_STATES).
  - On posedge: addr0_q <= addr0_i; addr1_q <= addr1_i; ren_q <= imem_ren_i && !load_we_i; cnt_q <= (imem_ren_i && !load_we_i) ? c : 0.
- Resulting latency:
  - WAIT_STATES=0: rvalid in the same cycle as ren; every cycle with a new address is valid.
  - WAIT_STATES=N: a request held stable for N+1 consecutive cycles gets rvalid on the (N+1)th cycle, and every further cycle it stays held.
- Restart conditions:
  - Any address change, ren drop, or load write restarts the count at 0.
  - An abandoned request (redirect: ren drops or the address jumps) produces no late rvalid.
- Errors:
  - imem_err_o = imem_ren_i && (either address misaligned or out of range), combinational.
  - rvalid is unaffected by errors; data is FILL_WORD.
- err_sticky_o:
  - Set on posedge when imem_err_o=1 or a bad load address is written.
  - Cleared on posedge when err_clr_i=1. If set and clear coincide, set wins.
  - Reset value 0.
- Output reset values (rst_ni=0):
  - imem_rvalid_o=0 (ren_q/cnt_q cleared; output follows the combinational rule).
  - imem_err_o combinational.
  - err_sticky_o=0.
  - rdata follows the array.
- Reset asserted mid-wait clears the count; a request held through reset release restarts counting from 0.
- Wraparound: addr1 = addr0+4 at the last word means addr1 is out of range. It returns FILL_WORD and raises imem_err_o; no index wraps.

Test Plan:
- WAIT_STATES=0: load 0x8B020020 at 0x0 and 0x8B030041 at 0x4; ren=1, addr0=0x0, addr1=0x4 -> same cycle rvalid=1, rdata0=0x8B020020, rdata1=0x8B030041, err=0.
- WAIT_STATES=2: hold ren with addr 0x8/0xC for 4 cycles -> rvalid 0,0,1,1. Change the address in cycle 2 -> rvalid 0 and the count restarts.
- Collision: load_we=1 to 0x8 while reading 0x8 -> rvalid=0, rdata old. Next cycle, read 0x8 -> new data, rvalid=1 (WAIT_STATES=0).
- DEPTH_WORDS=1024: read addr0=0xFFC, addr1=0x1000 -> rdata1=0xD503201F, imem_err_o=1, err_sticky_o=1 next cycle. err_clr_i pulse -> 0.
- Misaligned addr0=0x2 -> rdata0=FILL_WORD, err=1. Load to 0x5 -> array unchanged, sticky set.
- Assert rst_ni=0 after cycle 1 of a WAIT_STATES=3 wait, hold the request after release -> rvalid first on the 4th post-reset cycle; sticky=0 after reset.
